uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial front end of the command path. Samples the UART line from the host radio link,
//  rebuilds 8N1 frames, and presents each good byte with a one-cycle strobe.
//  Drives the message interpreter's FLAGDATAIN/DATAIN inputs directly:
//  data is valid in the same cycle as the strobe.
// PARAMETERS
//  CLKS_PER_BIT  5208  clock cycles per bit period (50 MHz / 9600 baud); must be >= 4
//  DATA_WIDTH    8     data bits per frame, sent LSB first
//  PARITY_ODD    0     parity sense when UART_RECEIVER_PARITY_EN is defined (0 even, 1 odd)
// PORTS
//  UART_RECEIVER_CLOCK_50          in   1           50 MHz system clock
//  UART_RECEIVER_RESET_InLow       in   1           async reset, active low
//  UART_RECEIVER_RX_In             in   1           raw serial line; idle high; asynchronous
//  UART_RECEIVER_DATAOUT_OutBus    out  DATA_WIDTH  last good byte; held until the next good byte
//  UART_RECEIVER_FLAGDATAOUT_OutHigh  out  1        one-cycle strobe: new byte on DATAOUT
//  UART_RECEIVER_FRAMEERROR_OutHigh   out  1        one-cycle pulse: stop bit sampled low
//  UART_RECEIVER_PARITYERROR_OutHigh  out  1        one-cycle pulse: parity mismatch (see CONFIG)
//  UART_RECEIVER_BUSY_OutHigh      out  1           high in every state except IDLE
// BEHAVIOUR
//  One clock. Reset is asynchronous and active-low.
//  Reset: all outputs 0; FSM -> IDLE; bit counter and index 0; synchroniser FFs forced to 1
//   (idle line, so no false start on release). Reset mid-frame aborts the frame; no strobe.
//  RX passes through a 2-FF synchroniser; rx_s is the FSM's only view of the line.
//  Baud counter cnt runs 0..CLKS_PER_BIT-1 and clears on every state change.
//  States:
//   IDLE   : rx_s==0 -> START, cnt=0.
//   START  : at cnt==CLKS_PER_BIT/2-1 (integer divide) sample rx_s.
//            0 -> DATA (cnt=0, idx=0). 1 -> IDLE as a glitch, no outputs.
//   DATA   : at cnt==CLKS_PER_BIT-1, shift rx_s into shreg[idx] and idx++.
//            After bit DATA_WIDTH-1 -> PARITY if enabled, else STOP.
//   PARITY : at cnt==CLKS_PER_BIT-1, compare rx_s with the computed parity and latch the mismatch.
//            Then -> STOP.
//   STOP   : at cnt==CLKS_PER_BIT-1 sample rx_s:
//            1 and no parity mismatch -> DATAOUT<=shreg, FLAG=1 for 1 cycle, -> IDLE
//            1 with mismatch          -> PARITYERROR=1 for 1 cycle, DATAOUT kept, -> IDLE
//            0                        -> FRAMEERROR=1 for 1 cycle, DATAOUT kept, -> WAIT_HI
//   WAIT_HI: stay until rx_s==1, then -> IDLE. A held-low (break) line gives exactly one error.
//  All samples are taken mid-bit. Error and flag pulses are mutually exclusive.
//  Latency: FLAG rises 2 + CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT (+CLKS_PER_BIT with
//   parity) cycles (+/-1) after the RX falling edge.
//  Back-to-back frames: a start bit right after the stop-bit sample is accepted. IDLE is
//   re-entered on the strobe cycle, so rx_s==0 on the next cycle starts the next frame.
//  Counters saturate by construction: cnt never exceeds CLKS_PER_BIT-1; idx never exceeds
//   DATA_WIDTH-1.
// CONFIGURATION
//  UART_RECEIVER_PARITY_EN defined:
//   - PARITY state is built; one parity bit is expected after the data bits.
//   - Parity sense is set by PARITY_ODD.
//  Not defined:
//   - No PARITY state; frames are 8N1.
//   - PARITYERROR_OutHigh is tied 0; the port stays for a uniform interface.
// TESTING (CLKS_PER_BIT=16 for simulation)
//  1 RESET_InLow=0, RX=1 for 10 cycles
//     -> DATAOUT=0x00, FLAG=0, FRAMEERROR=0, BUSY=0; none of these rise after release.
//  2 Send 0x14 as 8N1
//     -> exactly one FLAG pulse, with DATAOUT=0x14 in that cycle; FRAMEERROR=0.
//     -> BUSY falls on the strobe cycle.
//  3 RX low for 4 cycles, then high (glitch)
//     -> BUSY pulses, no FLAG, no error, DATAOUT unchanged at 0x14.
//  4 Send 0x0A with stop bit 0, then hold RX low 3 bit times, then high; then send 0x09
//     -> one FRAMEERROR pulse; DATAOUT stays 0x14.
//     -> then one FLAG with DATAOUT=0x09.
//  5 Send 0x01 and 0x3C with no idle gap
//     -> two FLAG pulses, DATAOUT 0x01 then 0x3C, no errors.
//  6 Assert reset during data bit 4 of 0x32, release, then resend 0x32
//     -> outputs 0 during reset; no strobe from the aborted frame.
//     -> one FLAG with DATAOUT=0x32.
//  7 (PARITY_EN, PARITY_ODD=0) send 0x21 with parity bit 1
//     -> PARITYERROR pulse, no FLAG.
//     -> resend 0x21 with parity bit 0 -> FLAG with DATAOUT=0x21.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver
//  Serial front end of the command path. Samples the asynchronous UART line
//  through a two-flop synchroniser and rebuilds 8N1 frames. Each good byte is
//  presented on DATAOUT together with a one-cycle FLAGDATAOUT strobe, so the
//  message interpreter can latch it in the same cycle.
//  Bad stop bits raise a one-cycle FRAMEERROR pulse. A held-low (break) line
//  produces a single error and then waits for the line to return high.
//  Optional feature: define UART_RECEIVER_PARITY_EN to expect one parity bit
//  after the data bits. PARITY_ODD selects the parity sense (0 even, 1 odd).
//  Without the macro, PARITYERROR is tied low and the port is kept only so the
//  interface stays the same in both builds.

module uart_receiver #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_WIDTH   = 8,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                  UART_RECEIVER_CLOCK_50,
  input  logic                  UART_RECEIVER_RESET_InLow,
  input  logic                  UART_RECEIVER_RX_In,
  output logic [DATA_WIDTH-1:0] UART_RECEIVER_DATAOUT_OutBus,
  output logic                  UART_RECEIVER_FLAGDATAOUT_OutHigh,
  output logic                  UART_RECEIVER_FRAMEERROR_OutHigh,
  output logic                  UART_RECEIVER_PARITYERROR_OutHigh,
  output logic                  UART_RECEIVER_BUSY_OutHigh
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // The baud counter compares against a full bit period, and against half a
  // bit period while checking the start bit, so all samples land mid-bit.
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HalfCnt = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    Idle,
    Start,
    Data,
`ifdef UART_RECEIVER_PARITY_EN
    Parity,
`endif
    Stop,
    WaitHi
  } stateT;

  stateT                 state;
  logic                  rxMeta;
  logic                  rxSync;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  flagOut;
  logic                  frameErr;
`ifdef UART_RECEIVER_PARITY_EN
  logic                  parityErr;
  logic                  parityMismatch;
`endif

  // Two-flop synchroniser; both flops reset to the idle (high) level so
  // releasing reset can never look like a start bit.
  always_ff @(posedge UART_RECEIVER_CLOCK_50 or negedge UART_RECEIVER_RESET_InLow) begin
    if (!UART_RECEIVER_RESET_InLow) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= UART_RECEIVER_RX_In;
      rxSync <= rxMeta;
    end
  end

  // Frame FSM: walks the start, data, parity and stop bits, and registers
  // the byte and the flag/error pulses. The pulses default to zero every cycle.
  always_ff @(posedge UART_RECEIVER_CLOCK_50 or negedge UART_RECEIVER_RESET_InLow) begin
    if (!UART_RECEIVER_RESET_InLow) begin
      state          <= Idle;
      cnt            <= '0;
      idx            <= '0;
      shreg          <= '0;
      dataOut        <= '0;
      flagOut        <= 1'b0;
      frameErr       <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      parityErr      <= 1'b0;
      parityMismatch <= 1'b0;
`endif
    end else begin
      flagOut   <= 1'b0;
      frameErr  <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      parityErr <= 1'b0;
`endif
      case (state)
        Idle: begin
          cnt <= '0;
          if (!rxSync) begin
            state <= Start;
          end
        end

        Start: begin
          if (cnt == HalfCnt) begin
            cnt <= '0;
            idx <= '0;
            if (!rxSync) begin
              state <= Data;
            end else begin
              state <= Idle;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        Data: begin
          if (cnt == LastCnt) begin
            cnt        <= '0;
            shreg[idx] <= rxSync;
            if (idx == LastIdx) begin
`ifdef UART_RECEIVER_PARITY_EN
              state <= Parity;
`else
              state <= Stop;
`endif
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

`ifdef UART_RECEIVER_PARITY_EN
        Parity: begin
          if (cnt == LastCnt) begin
            cnt            <= '0;
            parityMismatch <= (rxSync != ((^shreg) ^ PARITY_ODD));
            state          <= Stop;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif

        Stop: begin
          if (cnt == LastCnt) begin
            cnt <= '0;
            if (!rxSync) begin
              frameErr <= 1'b1;
              state    <= WaitHi;
`ifdef UART_RECEIVER_PARITY_EN
            end else if (parityMismatch) begin
              parityErr <= 1'b1;
              state     <= Idle;
`endif
            end else begin
              dataOut <= shreg;
              flagOut <= 1'b1;
              state   <= Idle;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WaitHi: begin
          cnt <= '0;
          if (rxSync) begin
            state <= Idle;
          end
        end

        default: begin
          cnt   <= '0;
          state <= Idle;
        end
      endcase
    end
  end

  assign UART_RECEIVER_DATAOUT_OutBus      = dataOut;
  assign UART_RECEIVER_FLAGDATAOUT_OutHigh = flagOut;
  assign UART_RECEIVER_FRAMEERROR_OutHigh  = frameErr;
  assign UART_RECEIVER_BUSY_OutHigh        = (state != Idle);
`ifdef UART_RECEIVER_PARITY_EN
  assign UART_RECEIVER_PARITYERROR_OutHigh = parityErr;
`else
  assign UART_RECEIVER_PARITYERROR_OutHigh = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//  Directed bench for uart_receiver at 16 clocks per bit. The line is driven
//  on falling clock edges. A monitor, also on falling edges, records every
//  strobe and error pulse for the directed checks.

module tb_uart_receiver;

  localparam int ClksPerBit = 16;

  logic       clock50;
  logic       rstN;
  logic       rx;
  logic [7:0] dataOut;
  logic       flag;
  logic       frameErr;
  logic       parityErr;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  int         cycleCount     = 0;
  int         flagCount      = 0;
  int         frameErrCount  = 0;
  int         parityErrCount = 0;
  int         busyRise       = 0;
  int         overlapCount   = 0;
  int         flagCycle      = 0;
  logic       busyAtFlag     = 1'b1;
  logic       prevBusy       = 1'b0;
  logic [7:0] flagData[$];

  uart_receiver #(
    .CLKS_PER_BIT(ClksPerBit),
    .DATA_WIDTH  (8),
    .PARITY_ODD  (1'b0)
  ) dut (
    .UART_RECEIVER_CLOCK_50           (clock50),
    .UART_RECEIVER_RESET_InLow        (rstN),
    .UART_RECEIVER_RX_In              (rx),
    .UART_RECEIVER_DATAOUT_OutBus     (dataOut),
    .UART_RECEIVER_FLAGDATAOUT_OutHigh(flag),
    .UART_RECEIVER_FRAMEERROR_OutHigh (frameErr),
    .UART_RECEIVER_PARITYERROR_OutHigh(parityErr),
    .UART_RECEIVER_BUSY_OutHigh       (busy)
  );

  // 50 MHz clock
  initial begin
    clock50 = 1'b0;
    forever #10 clock50 = ~clock50;
  end

  // Free-running cycle count used for latency measurement
  always @(posedge clock50) begin
    cycleCount <= cycleCount + 1;
  end

  // Monitor: records strobes, errors, busy rises and pulse overlaps away from the active edge
  always @(negedge clock50) begin
    if (flag) begin
      flagCount  <= flagCount + 1;
      flagData.push_back(dataOut);
      busyAtFlag <= busy;
      flagCycle  <= cycleCount;
    end
    if (frameErr) frameErrCount <= frameErrCount + 1;
    if (parityErr) parityErrCount <= parityErrCount + 1;
    if (busy && !prevBusy) busyRise <= busyRise + 1;
    if ((int'(flag) + int'(frameErr) + int'(parityErr)) > 1) overlapCount <= overlapCount + 1;
    prevBusy <= busy;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic bitTime(input logic value);
    rx = value;
    repeat (ClksPerBit) @(negedge clock50);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic badParity);
    bitTime(1'b0);
    for (int i = 0; i < 8; i++) bitTime(data[i]);
`ifdef UART_RECEIVER_PARITY_EN
    bitTime((^data) ^ badParity);
`endif
    bitTime(stopBit);
  endtask

  function automatic logic [7:0] lastData(input int back);
    logic [7:0] v;
    v = 8'hxx;
    if (flagData.size() > back) v = flagData[flagData.size() - 1 - back];
    return v;
  endfunction

  initial begin
    int baseFlag;
    int baseFrame;
    int baseParity;
    int baseBusy;
    int startCycle;
    int latency;

    $display("[TB] uart_receiver directed test, %0d clocks per bit", ClksPerBit);
    rx   = 1'b1;
    rstN = 1'b0;

    // 1: reset with idle line
    repeat (10) @(negedge clock50);
    checkOutput("rst_dataout", dataOut, 8'h00);
    checkOutput("rst_flag", flag, 1'b0);
    checkOutput("rst_frameerr", frameErr, 1'b0);
    checkOutput("rst_parityerr", parityErr, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    rstN = 1'b1;
    repeat (20) @(negedge clock50);
    checkOutput("post_rst_flags", flagCount, 0);
    checkOutput("post_rst_frameerrs", frameErrCount, 0);
    checkOutput("post_rst_busy", busyRise, 0);

    // 2: single byte 0x14
    startCycle = cycleCount;
    applyStimulus(8'h14, 1'b1, 1'b0);
    bitTime(1'b1);
    bitTime(1'b1);
    checkOutput("b14_flagcount", flagCount, 1);
    checkOutput("b14_data", lastData(0), 8'h14);
    checkOutput("b14_busy_at_flag", busyAtFlag, 1'b0);
    checkOutput("b14_frameerr", frameErrCount, 0);
    latency = flagCycle - startCycle;
    $display("[TB] strobe latency %0d cycles", latency);
    checkOutput("b14_latency_ok", (latency >= 153 && latency <= 155), 1'b1);

    // 3: short glitch low
    baseFlag = flagCount; baseFrame = frameErrCount; baseBusy = busyRise;
    rx = 1'b0;
    repeat (4) @(negedge clock50);
    bitTime(1'b1);
    bitTime(1'b1);
    checkOutput("glitch_busy_pulse", busyRise - baseBusy, 1);
    checkOutput("glitch_no_flag", flagCount - baseFlag, 0);
    checkOutput("glitch_no_err", frameErrCount - baseFrame, 0);
    checkOutput("glitch_dataout", dataOut, 8'h14);

    // 4: bad stop bit followed by break, then a good byte
    baseFlag = flagCount; baseFrame = frameErrCount;
    applyStimulus(8'h0A, 1'b0, 1'b0);
    bitTime(1'b0);
    bitTime(1'b0);
    bitTime(1'b0);
    bitTime(1'b1);
    bitTime(1'b1);
    checkOutput("frame_err_once", frameErrCount - baseFrame, 1);
    checkOutput("frame_no_flag", flagCount - baseFlag, 0);
    checkOutput("frame_dataout_kept", dataOut, 8'h14);
    applyStimulus(8'h09, 1'b1, 1'b0);
    bitTime(1'b1);
    checkOutput("after_break_flag", flagCount - baseFlag, 1);
    checkOutput("after_break_data", lastData(0), 8'h09);
    checkOutput("after_break_err_once", frameErrCount - baseFrame, 1);

    // 5: back-to-back frames
    baseFlag = flagCount; baseFrame = frameErrCount;
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    bitTime(1'b1);
    checkOutput("b2b_flagcount", flagCount - baseFlag, 2);
    checkOutput("b2b_first", lastData(1), 8'h01);
    checkOutput("b2b_second", lastData(0), 8'h3C);
    checkOutput("b2b_no_err", frameErrCount - baseFrame, 0);

    // 6: reset during data bit 4 of 0x32, then resend
    baseFlag = flagCount;
    bitTime(1'b0);
    for (int i = 0; i < 4; i++) bitTime(((8'h32 >> i) & 8'h01) != 8'h00);
    rx = 1'b1;
    repeat (ClksPerBit / 2) @(negedge clock50);
    rstN = 1'b0;
    repeat (3) @(negedge clock50);
    checkOutput("midrst_dataout", dataOut, 8'h00);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_flag", flag, 1'b0);
    repeat (7) @(negedge clock50);
    rstN = 1'b1;
    bitTime(1'b1);
    bitTime(1'b1);
    bitTime(1'b1);
    checkOutput("aborted_no_flag", flagCount - baseFlag, 0);
    applyStimulus(8'h32, 1'b1, 1'b0);
    bitTime(1'b1);
    checkOutput("resend_flag", flagCount - baseFlag, 1);
    checkOutput("resend_data", lastData(0), 8'h32);

`ifdef UART_RECEIVER_PARITY_EN
    // 7: parity mismatch, then correct parity
    baseFlag = flagCount; baseParity = parityErrCount;
    applyStimulus(8'h21, 1'b1, 1'b1);
    bitTime(1'b1);
    checkOutput("parity_err_pulse", parityErrCount - baseParity, 1);
    checkOutput("parity_no_flag", flagCount - baseFlag, 0);
    checkOutput("parity_dataout_kept", dataOut, 8'h32);
    applyStimulus(8'h21, 1'b1, 1'b0);
    bitTime(1'b1);
    checkOutput("parity_ok_flag", flagCount - baseFlag, 1);
    checkOutput("parity_ok_data", lastData(0), 8'h21);
`else
    baseParity = parityErrCount;
    checkOutput("no_parity_errs", parityErrCount - baseParity + parityErrCount, 0);
`endif

    checkOutput("pulse_overlap", overlapCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
